// File: rtl/irq_ctrl_pkg.sv
// Shared SoC definitions for the interrupt controller: register word indices,
// CAUSE field layout and a lowest-set-bit helper.
package irq_ctrl_pkg;

    typedef enum logic [2:0] {
        REG_PEND  = 3'd0,
        REG_MASK  = 3'd1,
        REG_EDGE  = 3'd2,
        REG_CLEAR = 3'd3,
        REG_CAUSE = 3'd4
    } reg_e;

    localparam int CAUSE_VALID_BIT = 31;
    localparam int MAX_SRC         = 8;

    // Priority encoder: index of the lowest set bit, 0 when none is set.
    function automatic logic [2:0] lowest_set(input logic [MAX_SRC-1:0] v);
        lowest_set = 3'd0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

endpackage

// File: rtl/irq_debounce.sv
// One interrupt source: 2-flop synchronizer, followed by a stability counter
// when IRQ_DEBOUNCE_EN is defined (otherwise the synchronizer output is used).
module irq_debounce #(
    parameter int DB_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic filt_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
        end
    end

`ifdef IRQ_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;

    // Counter runs only while the synchronized value disagrees with the
    // filtered one; any agreement restarts the window.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_q != filt_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                filt_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt_o = filt_q;
`else
    localparam int DB_UNUSED = DB_CYCLES;

    assign filt_o = sync_q;
`endif

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: NSRC synchronized sources, edge/level pending latch,
// mask, write-1-to-clear, lowest-index CAUSE and 4 paired INT lines.
// Optional input debounce is enabled with the IRQ_DEBOUNCE_EN macro.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NSRC      = 8,
    parameter int DB_CYCLES = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_in,
    input  logic            we,
    input  logic [2:0]      addr,
    input  logic [31:0]     wd,
    output logic [31:0]     rd,
    output logic [3:0]      INT
);
    logic [NSRC-1:0]    filt;
    logic [NSRC-1:0]    filt_prev_q;
    logic [NSRC-1:0]    pend_q, pend_d;
    logic [NSRC-1:0]    mask_q, mask_d;
    logic [NSRC-1:0]    edge_q, edge_d;
    logic [NSRC-1:0]    clr;
    logic [NSRC-1:0]    rise;
    logic [MAX_SRC-1:0] pm_next;
    logic [MAX_SRC-1:0] pm_cur;
    logic [3:0]         int_q, int_d;
    logic               cause_vld;
    logic [2:0]         cause_idx;
    logic               wd_unused;

    assign wd_unused = ^wd[31:NSRC];

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        irq_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw_i (irq_in[i]),
            .filt_o(filt[i])
        );
    end

    always_comb begin
        mask_d = mask_q;
        edge_d = edge_q;
        clr    = '0;
        if (we) begin
            case (reg_e'(addr))
                REG_MASK:  mask_d = wd[NSRC-1:0];
                REG_EDGE:  edge_d = wd[NSRC-1:0];
                REG_CLEAR: clr    = wd[NSRC-1:0];
                default:   ;
            endcase
        end
    end

    assign rise = filt & ~filt_prev_q;

    // A mode change wipes the bit; a new edge wins over a same-cycle clear.
    assign pend_d = ~(edge_d ^ edge_q)
                  & ((edge_q & ((pend_q & ~clr) | rise)) | (~edge_q & filt));

    always_comb begin
        pm_next             = '0;
        pm_next[NSRC-1:0]   = pend_q & mask_d;
        for (int k = 0; k < 4; k++) begin
            int_d[k] = |pm_next[2*k +: 2];
        end
    end

    always_comb begin
        pm_cur           = '0;
        pm_cur[NSRC-1:0] = pend_q & mask_q;
        cause_vld        = |pm_cur;
        cause_idx        = lowest_set(pm_cur);
    end

    always_comb begin
        rd = '0;
        case (reg_e'(addr))
            REG_PEND:  rd[NSRC-1:0] = pend_q;
            REG_MASK:  rd[NSRC-1:0] = mask_q;
            REG_EDGE:  rd[NSRC-1:0] = edge_q;
            REG_CAUSE: begin
                rd[CAUSE_VALID_BIT] = cause_vld;
                rd[2:0]             = cause_idx;
            end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_prev_q <= '0;
            pend_q      <= '0;
            mask_q      <= '0;
            edge_q      <= '1;
            int_q       <= '0;
        end else begin
            filt_prev_q <= filt;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            edge_q      <= edge_d;
            int_q       <= int_d;
        end
    end

    assign INT = int_q;

endmodule
